// File: rtl/proc_run_controller.sv
// proc_run_controller: sequences core reset, counts run cycles and flag rises, ends runs on halt pattern or cycle budget
module proc_run_controller #(
  parameter int N_FLAGS      = 1,
  parameter int CNT_W        = 16,
  parameter int RESET_CYCLES = 1,
  parameter int MAX_CYCLES   = 30,
  parameter int HALT_IDX     = 0,
  parameter int HALT_RUN     = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [N_FLAGS-1:0]       flags,
  output logic                     core_reset_n,
  output logic                     running,
  output logic                     done,
  output logic                     timeout,
  output logic                     halted,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [N_FLAGS*CNT_W-1:0] rise_count
);
  typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;
  localparam logic [CNT_W-1:0] SAT = '1;
  state_t state, state_nx;
  logic [CNT_W-1:0] rst_cnt, halt_cnt, cyc_nx, halt_nx;
  logic [N_FLAGS-1:0] prev;
  logic [N_FLAGS*CNT_W-1:0] rise_nx;
  logic halt_hit, time_hit, launch;
  always_comb begin
    cyc_nx   = cycle_count == SAT ? cycle_count : cycle_count + 1'b1;
    halt_nx  = !flags[HALT_IDX] ? '0 : halt_cnt == SAT ? halt_cnt : halt_cnt + 1'b1;
    halt_hit = (HALT_RUN != 0) && halt_nx == CNT_W'(HALT_RUN);
    time_hit = cyc_nx == CNT_W'(MAX_CYCLES);
    launch   = start && (state == IDLE || state == DONE);
    rise_nx  = rise_count;
    for (int i = 0; i < N_FLAGS; i++)
      rise_nx[i*CNT_W +: CNT_W] = (flags[i] && !prev[i] && rise_count[i*CNT_W +: CNT_W] != SAT)
                                  ? rise_count[i*CNT_W +: CNT_W] + 1'b1 : rise_count[i*CNT_W +: CNT_W];
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = launch ? RST : state;
      RST:        state_nx = abort ? IDLE : rst_cnt == CNT_W'(RESET_CYCLES - 1) ? RUN : RST;
      RUN:        state_nx = abort ? IDLE : (halt_hit || time_hit) ? DONE : RUN;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      rst_cnt     <= '0;
      halt_cnt    <= '0;
      prev        <= '0;
      cycle_count <= '0;
      rise_count  <= '0;
      timeout     <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state <= state_nx;
      if (launch) begin
        rst_cnt     <= '0;
        halt_cnt    <= '0;
        prev        <= '0;
        cycle_count <= '0;
        rise_count  <= '0;
        timeout     <= 1'b0;
        halted      <= 1'b0;
      end else if (state == RST) begin
        rst_cnt <= rst_cnt + 1'b1;
      end else if (state == RUN) begin
        // the aborted cycle still counts; only the exit status is suppressed
        cycle_count <= cyc_nx;
        rise_count  <= rise_nx;
        halt_cnt    <= halt_nx;
        prev        <= flags;
        if (!abort) begin
          halted  <= halt_hit;
          timeout <= time_hit && !halt_hit;
        end
      end
    end
  end
  assign core_reset_n = state == RUN;
  assign running      = state == RUN;
  assign done         = state == DONE;
endmodule
